cpu_bus_ctrl: RTL

- M-cycle bus sequencer for the SM83 core.
- Sits directly downstream of the decoder/control unit. Each M-cycle it consumes one bus request (bus_opcode_t: IDLE, IF, WRITE, READ) plus address and write data.
- Runs the request over a 4-T-state external memory bus, captures read data or the fetched opcode, and computes the incremented/decremented address (IDU) for the register file.

---
 rtl/cpu_bus_ctrl.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/cpu_bus_ctrl.sv
// M-cycle bus sequencer for the SM83 core: runs one bus request over four
// T-states, captures read/fetch data and produces the IDU address result.
module cpu_bus_ctrl #(
    parameter int                 ADDR_W   = 16,
    parameter int                 DATA_W   = 8,
    parameter logic [DATA_W-1:0]  IR_RESET = 8'h00
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ce,
    input  logic [1:0]        op_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [1:0]        idu_op_i,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    output logic              mem_rd_o,
    output logic              mem_wr_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic [DATA_W-1:0] rdata_o,
    output logic [DATA_W-1:0] ir_o,
    output logic [ADDR_W-1:0] idu_o,
    output logic [1:0]        tph_o,
    output logic              m_start_o,
    output logic              m_done_o
);

    typedef enum logic [1:0] {
        BUS_IDLE  = 2'b00,
        BUS_IF    = 2'b01,
        BUS_WRITE = 2'b10,
        BUS_READ  = 2'b11
    } bus_opcode_t;

    typedef enum logic [1:0] {
        T0 = 2'b00,
        T1 = 2'b01,
        T2 = 2'b10,
        T3 = 2'b11
    } tph_state_t;

    localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};

    tph_state_t        tph_r;
    tph_state_t        tph_next_s;
    bus_opcode_t       op_r;
    logic [ADDR_W-1:0] addr_r;
    logic [DATA_W-1:0] wdata_r;
    logic [1:0]        iduop_r;
    logic [DATA_W-1:0] rdata_r;
    logic [DATA_W-1:0] ir_r;
    logic [ADDR_W-1:0] idu_r;
    logic [ADDR_W-1:0] idu_next_s;
    logic              is_read_op_s;

    // T-phase next-state: advance only on enabled T-states.
    always_comb begin
        tph_next_s = tph_r;
        if (ce) begin
            case (tph_r)
                T0:      tph_next_s = T1;
                T1:      tph_next_s = T2;
                T2:      tph_next_s = T3;
                T3:      tph_next_s = T0;
                default: tph_next_s = T0;
            endcase
        end else begin
            tph_next_s = tph_r;
        end
    end

    // T-phase state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            tph_r <= T0;
        end else begin
            tph_r <= tph_next_s;
        end
    end

    // Request latch: inputs are only looked at on the M-cycle's first T-state.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_r    <= BUS_IDLE;
            addr_r  <= ADDR_ZERO;
            wdata_r <= DATA_ZERO;
            iduop_r <= 2'b00;
        end else if (ce && (tph_r == T0)) begin
            op_r    <= bus_opcode_t'(op_i);
            addr_r  <= addr_i;
            wdata_r <= wdata_i;
            iduop_r <= idu_op_i;
        end
    end

    // IDU arithmetic; wraps naturally at the address width.
    always_comb begin
        idu_next_s = addr_r;
        case (iduop_r)
            2'b01:   idu_next_s = addr_r + ADDR_ONE;
            2'b10:   idu_next_s = addr_r - ADDR_ONE;
            default: idu_next_s = addr_r;
        endcase
    end

    // IDU result register, updated for every op including IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            idu_r <= ADDR_ZERO;
        end else if (ce && (tph_r == T1)) begin
            idu_r <= idu_next_s;
        end
    end

    // Read/fetch capture at the end of the strobe window.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_r <= DATA_ZERO;
            ir_r    <= IR_RESET;
        end else if (ce && (tph_r == T2)) begin
            case (op_r)
                BUS_READ: rdata_r <= mem_rdata_i;
                BUS_IF:   ir_r    <= mem_rdata_i;
                default: begin
                    rdata_r <= rdata_r;
                    ir_r    <= ir_r;
                end
            endcase
        end
    end

    // Strobes are decoded from registered state only, so they stay put while ce is low.
    assign is_read_op_s = (op_r == BUS_IF) || (op_r == BUS_READ);
    assign mem_rd_o     = is_read_op_s && ((tph_r == T1) || (tph_r == T2));
    assign mem_wr_o     = (op_r == BUS_WRITE) && (tph_r == T2);

    assign mem_addr_o  = addr_r;
    assign mem_wdata_o = wdata_r;
    assign rdata_o     = rdata_r;
    assign ir_o        = ir_r;
    assign idu_o       = idu_r;
    assign tph_o       = tph_r;
    assign m_start_o   = ce && (tph_r == T0);
    assign m_done_o    = ce && (tph_r == T3);

endmodule
